// File: rtl/perf_event_counters_if.sv
// Event and read-port bundle for the performance counter bank.
// The core/bench drives through master; the counter bank is the slave.
`timescale 1ns/1ps

interface perf_event_counters_if #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned SEL_W = $clog2(NUM_CH + 1);

    logic              en;
    logic [NUM_CH-1:0] event_i;
    logic              halt;
    logic              clear;
    logic              snap;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_shadow;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH:0]   overflow;
    logic              frozen;

    modport master (
        output en, event_i, halt, clear, snap, rd_req, rd_sel, rd_shadow,
        input  rd_valid, rd_data, overflow, frozen
    );

    modport slave (
        input  en, event_i, halt, clear, snap, rd_req, rd_sel, rd_shadow,
        output rd_valid, rd_data, overflow, frozen
    );
endinterface

// File: rtl/perf_event_counters.sv
// Bank of NUM_CH event counters plus a cycle counter, with shadow snapshot,
// sticky overflow flags, halt freeze and a registered one-cycle read port.
`timescale 1ns/1ps

module perf_event_counters #(
    parameter int unsigned NUM_CH   = 6,
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned SEL_W    = $clog2(NUM_CH + 1)
) (
    input logic                  clk,
    input logic                  rst,
    perf_event_counters_if.slave bus
);
    localparam int unsigned NumCnt = NUM_CH + 1;

    // Index NUM_CH is the free-running cycle counter.
    logic [NUM_CH:0][CNT_W-1:0] cntQ;
    logic [NUM_CH:0][CNT_W-1:0] cntD;
    logic [NUM_CH:0][CNT_W-1:0] shdQ;
    logic [NUM_CH:0]            ovfQ;
    logic [NUM_CH:0]            ovfSet;
    logic [NUM_CH:0]            incEn;
    logic                       frozenQ;
    logic                       rdValidQ;
    logic [CNT_W-1:0]           rdDataQ;
    logic [CNT_W-1:0]           rdDataD;

    always_comb begin
        incEn = {1'b1, bus.event_i} & {NumCnt{bus.en & ~frozenQ}};
    end

    always_comb begin
        cntD   = cntQ;
        ovfSet = '0;
        for (int k = 0; k < NumCnt; k++) begin
            if (incEn[k]) begin
                if (&cntQ[k]) begin
                    ovfSet[k] = 1'b1;
                    cntD[k]   = SATURATE ? cntQ[k] : '0;
                end else begin
                    cntD[k] = cntQ[k] + CNT_W'(1);
                end
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rdDataD = '0;
        for (int k = 0; k < NumCnt; k++) begin
            if (bus.rd_sel == SEL_W'(k)) begin
                rdDataD = bus.rd_shadow ? shdQ[k] : cntQ[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntQ     <= '0;
            shdQ     <= '0;
            ovfQ     <= '0;
            frozenQ  <= 1'b0;
            rdValidQ <= 1'b0;
            rdDataQ  <= '0;
        end else begin
            if (bus.clear) begin
                cntQ    <= '0;
                shdQ    <= '0;
                ovfQ    <= '0;
                frozenQ <= 1'b0;
            end else begin
                cntQ <= cntD;
                ovfQ <= ovfQ | ovfSet;
                if (bus.snap) begin
                    shdQ <= cntQ;
                end
                if (bus.halt) begin
                    frozenQ <= 1'b1;
                end
            end
            // Reads see pre-clear, pre-increment register contents.
            rdValidQ <= bus.rd_req;
            if (bus.rd_req) begin
                rdDataQ <= rdDataD;
            end
        end
    end

    assign bus.rd_valid = rdValidQ;
    assign bus.rd_data  = rdDataQ;
    assign bus.overflow = ovfQ;
    assign bus.frozen   = frozenQ;

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a 32-bit saturating bank plus
// 8-bit saturating and wrapping banks for the overflow boundaries.
`timescale 1ns/1ps

module tb_perf_event_counters;
    localparam int unsigned NCH = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    perf_event_counters_if #(.NUM_CH(NCH), .CNT_W(32)) busMain ();
    perf_event_counters_if #(.NUM_CH(NCH), .CNT_W(8))  busSat ();
    perf_event_counters_if #(.NUM_CH(NCH), .CNT_W(8))  busWrap ();

    perf_event_counters #(.NUM_CH(NCH), .CNT_W(32), .SATURATE(1'b1)) dutMain (
        .clk(clk), .rst(rst), .bus(busMain)
    );
    perf_event_counters #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(1'b1)) dutSat (
        .clk(clk), .rst(rst), .bus(busSat)
    );
    perf_event_counters #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(1'b0)) dutWrap (
        .clk(clk), .rst(rst), .bus(busWrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        busMain.en = 0; busMain.event_i = '0; busMain.halt = 0; busMain.clear = 0;
        busMain.snap = 0; busMain.rd_req = 0; busMain.rd_sel = '0; busMain.rd_shadow = 0;
        busSat.en = 0; busSat.event_i = '0; busSat.halt = 0; busSat.clear = 0;
        busSat.snap = 0; busSat.rd_req = 0; busSat.rd_sel = '0; busSat.rd_shadow = 0;
        busWrap.en = 0; busWrap.event_i = '0; busWrap.halt = 0; busWrap.clear = 0;
        busWrap.snap = 0; busWrap.rd_req = 0; busWrap.rd_sel = '0; busWrap.rd_shadow = 0;
    endtask

    task automatic test_reset();
        idleAll();
        rst = 1'b0;
        repeat (2) tick();
        nChecks++;
        if (busMain.rd_valid !== 1'b0) begin
            nFails++; $display("FAIL reset_rd_valid: got %0b expected 0", busMain.rd_valid);
        end
        nChecks++;
        if (busMain.rd_data !== 32'd0) begin
            nFails++; $display("FAIL reset_rd_data: got %0h expected 0", busMain.rd_data);
        end
        nChecks++;
        if (busMain.overflow !== 7'd0) begin
            nFails++; $display("FAIL reset_overflow: got %0b expected 0", busMain.overflow);
        end
        nChecks++;
        if (busMain.frozen !== 1'b0) begin
            nFails++; $display("FAIL reset_frozen: got %0b expected 0", busMain.frozen);
        end
    endtask

    task automatic test_basic_count();
        rst = 1'b1;
        busMain.en = 1; busMain.event_i = 6'b000001;
        repeat (10) tick();
        for (int i = 0; i < 10; i++) begin
            busMain.event_i = (i % 2 == 0) ? 6'b000100 : 6'b000000;
            tick();
        end
        busMain.en = 0; busMain.event_i = '0;
        busMain.rd_req = 1; busMain.rd_sel = 3'd0; busMain.rd_shadow = 0;
        nChecks++;
        if (busMain.rd_valid !== 1'b0) begin
            nFails++; $display("FAIL basic_valid_before: got %0b expected 0", busMain.rd_valid);
        end
        tick();
        nChecks++;
        if (busMain.rd_valid !== 1'b1 || busMain.rd_data !== 32'd10) begin
            nFails++; $display("FAIL basic_ch0: got v=%0b d=%0d expected v=1 d=10",
                               busMain.rd_valid, busMain.rd_data);
        end
        busMain.rd_sel = 3'd2;
        tick();
        nChecks++;
        if (busMain.rd_valid !== 1'b1 || busMain.rd_data !== 32'd5) begin
            nFails++; $display("FAIL basic_ch2: got v=%0b d=%0d expected v=1 d=5",
                               busMain.rd_valid, busMain.rd_data);
        end
        busMain.rd_sel = 3'd6;
        tick();
        nChecks++;
        if (busMain.rd_valid !== 1'b1 || busMain.rd_data !== 32'd20) begin
            nFails++; $display("FAIL basic_cycles: got v=%0b d=%0d expected v=1 d=20",
                               busMain.rd_valid, busMain.rd_data);
        end
        busMain.rd_req = 0;
        tick();
        nChecks++;
        if (busMain.rd_valid !== 1'b0 || busMain.rd_data !== 32'd20) begin
            nFails++; $display("FAIL basic_hold: got v=%0b d=%0d expected v=0 d=20",
                               busMain.rd_valid, busMain.rd_data);
        end
    endtask

    task automatic test_halt_freeze();
        busMain.en = 1; busMain.event_i = 6'b000001; busMain.halt = 1;
        tick();
        nChecks++;
        if (busMain.frozen !== 1'b1) begin
            nFails++; $display("FAIL halt_frozen: got %0b expected 1", busMain.frozen);
        end
        busMain.halt = 0;
        for (int i = 0; i < 20; i++) begin
            busMain.event_i = (i % 2 == 0) ? 6'b111111 : 6'b000000;
            tick();
        end
        busMain.en = 0; busMain.event_i = '0;
        busMain.rd_req = 1; busMain.rd_sel = 3'd0;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd11) begin
            nFails++; $display("FAIL halt_ch0: got %0d expected 11", busMain.rd_data);
        end
        busMain.rd_sel = 3'd2;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd5) begin
            nFails++; $display("FAIL halt_ch2: got %0d expected 5", busMain.rd_data);
        end
        busMain.rd_sel = 3'd1;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd0) begin
            nFails++; $display("FAIL halt_ch1: got %0d expected 0", busMain.rd_data);
        end
        busMain.rd_sel = 3'd6;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd21) begin
            nFails++; $display("FAIL halt_cycles: got %0d expected 21", busMain.rd_data);
        end
        busMain.rd_req = 0;
        nChecks++;
        if (busMain.frozen !== 1'b1) begin
            nFails++; $display("FAIL halt_still_frozen: got %0b expected 1", busMain.frozen);
        end
    endtask

    task automatic test_clear_priority();
        busMain.en = 1; busMain.event_i = 6'b111111; busMain.halt = 1;
        busMain.snap = 1; busMain.clear = 1;
        busMain.rd_req = 1; busMain.rd_sel = 3'd0; busMain.rd_shadow = 0;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd11) begin
            nFails++; $display("FAIL clear_preclear_read: got %0d expected 11", busMain.rd_data);
        end
        nChecks++;
        if (busMain.frozen !== 1'b0 || busMain.overflow !== 7'd0) begin
            nFails++; $display("FAIL clear_flags: got frozen=%0b ovf=%0b expected 0 0",
                               busMain.frozen, busMain.overflow);
        end
        busMain.en = 0; busMain.event_i = '0; busMain.halt = 0;
        busMain.snap = 0; busMain.clear = 0;
        for (int i = 0; i < 4; i++) begin
            busMain.rd_sel = (i < 2) ? 3'd0 : 3'd6;
            busMain.rd_shadow = i[0];
            tick();
            nChecks++;
            if (busMain.rd_data !== 32'd0) begin
                nFails++; $display("FAIL clear_read_%0d: got %0d expected 0", i, busMain.rd_data);
            end
        end
        busMain.rd_req = 0; busMain.rd_shadow = 0;
    endtask

    task automatic test_snapshot();
        busMain.en = 1; busMain.event_i = 6'b000001;
        repeat (7) tick();
        busMain.snap = 1;
        tick();
        busMain.snap = 0;
        repeat (5) tick();
        busMain.en = 0; busMain.event_i = '0;
        busMain.rd_req = 1; busMain.rd_sel = 3'd0; busMain.rd_shadow = 1;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd7) begin
            nFails++; $display("FAIL snap_shadow_ch0: got %0d expected 7", busMain.rd_data);
        end
        busMain.rd_shadow = 0;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd13) begin
            nFails++; $display("FAIL snap_live_ch0: got %0d expected 13", busMain.rd_data);
        end
        busMain.rd_sel = 3'd6; busMain.rd_shadow = 1;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd7) begin
            nFails++; $display("FAIL snap_shadow_cycles: got %0d expected 7", busMain.rd_data);
        end
        busMain.rd_shadow = 0;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd13) begin
            nFails++; $display("FAIL snap_live_cycles: got %0d expected 13", busMain.rd_data);
        end
        busMain.rd_req = 0;
    endtask

    task automatic test_saturate_wrap();
        busSat.en = 1; busSat.event_i = 6'b000001;
        busWrap.en = 1; busWrap.event_i = 6'b000001;
        repeat (255) tick();
        nChecks++;
        if (busSat.overflow !== 7'd0 || busWrap.overflow !== 7'd0) begin
            nFails++; $display("FAIL ovf_at_255: got sat=%0b wrap=%0b expected 0 0",
                               busSat.overflow, busWrap.overflow);
        end
        for (int i = 255; i < 300; i++) begin
            busWrap.en = (i < 257);
            tick();
        end
        busSat.en = 0; busSat.event_i = '0;
        busWrap.en = 0; busWrap.event_i = '0;
        nChecks++;
        if (busSat.overflow !== 7'b1000001) begin
            nFails++; $display("FAIL sat_overflow: got %0b expected 1000001", busSat.overflow);
        end
        nChecks++;
        if (busWrap.overflow !== 7'b1000001) begin
            nFails++; $display("FAIL wrap_overflow: got %0b expected 1000001", busWrap.overflow);
        end
        busSat.rd_req = 1; busSat.rd_sel = 3'd0;
        busWrap.rd_req = 1; busWrap.rd_sel = 3'd0;
        tick();
        nChecks++;
        if (busSat.rd_data !== 8'hFF) begin
            nFails++; $display("FAIL sat_ch0: got %0h expected ff", busSat.rd_data);
        end
        nChecks++;
        if (busWrap.rd_data !== 8'h01) begin
            nFails++; $display("FAIL wrap_ch0: got %0h expected 01", busWrap.rd_data);
        end
        busSat.rd_sel = 3'd6; busWrap.rd_sel = 3'd6;
        tick();
        nChecks++;
        if (busSat.rd_data !== 8'hFF || busWrap.rd_data !== 8'h01) begin
            nFails++; $display("FAIL ovf_cycles: got sat=%0h wrap=%0h expected ff 01",
                               busSat.rd_data, busWrap.rd_data);
        end
        busSat.rd_req = 0; busWrap.rd_req = 0;
    endtask

    task automatic test_range_and_reset();
        busMain.rd_req = 1; busMain.rd_sel = 3'd7; busMain.rd_shadow = 0;
        tick();
        nChecks++;
        if (busMain.rd_valid !== 1'b1 || busMain.rd_data !== 32'd0) begin
            nFails++; $display("FAIL range_read: got v=%0b d=%0d expected v=1 d=0",
                               busMain.rd_valid, busMain.rd_data);
        end
        busMain.rd_req = 0;
        busMain.en = 1; busMain.event_i = 6'b111111; busMain.halt = 1;
        tick();
        busMain.en = 0; busMain.event_i = '0; busMain.halt = 0;
        busMain.rd_req = 1; busMain.rd_sel = 3'd0;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd14 || busMain.frozen !== 1'b1) begin
            nFails++; $display("FAIL prereset_state: got d=%0d frozen=%0b expected 14 1",
                               busMain.rd_data, busMain.frozen);
        end
        #3;
        rst = 1'b0;
        #1;
        nChecks++;
        if (busMain.rd_valid !== 1'b0 || busMain.rd_data !== 32'd0 || busMain.frozen !== 1'b0) begin
            nFails++; $display("FAIL async_reset_main: got v=%0b d=%0d f=%0b expected 0 0 0",
                               busMain.rd_valid, busMain.rd_data, busMain.frozen);
        end
        nChecks++;
        if (busSat.overflow !== 7'd0 || busWrap.overflow !== 7'd0 || busSat.rd_data !== 8'd0) begin
            nFails++; $display("FAIL async_reset_ovf: got sat=%0b wrap=%0b d=%0h expected 0 0 0",
                               busSat.overflow, busWrap.overflow, busSat.rd_data);
        end
        busMain.rd_req = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        busMain.en = 1; busMain.event_i = 6'b000001;
        tick();
        busMain.en = 0; busMain.event_i = '0;
        busMain.rd_req = 1; busMain.rd_sel = 3'd0;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd1) begin
            nFails++; $display("FAIL post_reset_ch0: got %0d expected 1", busMain.rd_data);
        end
        busMain.rd_sel = 3'd6;
        tick();
        nChecks++;
        if (busMain.rd_data !== 32'd1) begin
            nFails++; $display("FAIL post_reset_cycles: got %0d expected 1", busMain.rd_data);
        end
        busMain.rd_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_halt_freeze();
        test_clear_priority();
        test_snapshot();
        test_saturate_wrap();
        test_range_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
